// File: rtl/ssd_scan_if.sv
// Bus between a datapath and the seven-segment scanner: value/dp/load/enable
// flow toward the scanner; anode, segment and frame signals flow back out.
interface ssd_scan_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                enable;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp_n;
  logic                frame;

  modport master (
    output value, dp, load, enable,
    input  an, seg, dp_n, frame
  );

  modport slave (
    input  value, dp, load, enable,
    output an, seg, dp_n, frame
  );
endinterface

// File: rtl/ssd_scan.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered
// display image, leading-zero blanking and a one-cycle frame marker.
module ssd_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic      clk,
  input  logic      rst,
  ssd_scan_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PC_LAST  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         r_pcnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_pend_val;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_valid;
  logic [4*DIGITS-1:0]   r_disp_val;
  logic [DIGITS-1:0]     r_disp_dp;
  logic                  r_wrap_d;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic                  r_dp_n;
  logic                  r_frame;

  logic                  w_tc;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_blank;
  logic [DIGITS-1:0]     w_blank_vec;
  logic [DIGITS-1:0]     w_an_sel;
  logic [6:0]            w_seg_dec;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Terminal count only advances while enabled, so transfers freeze when dark.
  assign w_tc      = bus.enable && (r_pcnt == PC_LAST);
  assign w_wrap    = w_tc && (r_idx == IDX_LAST);
  assign w_seg_dec = f_decode(w_nib);

  // Scan from the top digit down; a digit is blank until something non-zero
  // (nibble or dp) has been seen at or above it.
  always_comb begin : blank_scan
    logic lz_seen;
    lz_seen     = 1'b0;
    w_blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_seen = lz_seen | (r_disp_val[4*i +: 4] != 4'h0) | r_disp_dp[i];
      if ((BLANK_LZ != 0) && (i > 0) && !lz_seen) begin
        w_blank_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp_sel    = r_disp_dp[i];
        w_blank     = w_blank_vec[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_wrap_d     <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_pcnt <= w_tc ? '0 : r_pcnt + 1'b1;
        if (w_tc) begin
          r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      // A load coinciding with the wrap lands in pending only.
      if (bus.load) begin
        r_pend_val   <= bus.value;
        r_pend_dp    <= bus.dp;
        r_pend_valid <= 1'b1;
      end else if (w_wrap) begin
        r_pend_valid <= 1'b0;
      end
      if (w_wrap && r_pend_valid) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      r_wrap_d <= w_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      if (bus.enable && !w_blank) begin
        r_an   <= w_an_sel;
        r_seg  <= w_seg_dec;
        r_dp_n <= ~w_dp_sel;
      end else begin
        r_an   <= '1;
        r_seg  <= 7'h7F;
        r_dp_n <= 1'b1;
      end
      r_frame <= bus.enable && r_wrap_d;
    end
  end

  assign bus.an    = r_an;
  assign bus.seg   = r_seg;
  assign bus.dp_n  = r_dp_n;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan: a 4-digit scanner and a 1-digit scanner,
// both with a 4-cycle prescaler, share one clock and reset.
module tb_ssd_scan;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [3:0] an_tab[4]    = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_1234[4]  = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] seg_tab[16]  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_if #(.DIGITS(4)) ifa ();
  ssd_scan_if #(.DIGITS(1)) ifb ();

  ssd_scan #(.DIGITS(4), .PRESCALE(4), .BLANK_LZ(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ssd_scan #(.DIGITS(1), .PRESCALE(4), .BLANK_LZ(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench just after the last reset-held edge (edge 0)
  task automatic do_reset();
    rst        = 1'b1;
    ifa.load   = 1'b0;
    ifb.load   = 1'b0;
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_a(input logic [15:0] v, input logic [3:0] d);
    ifa.value = v;
    ifa.dp    = d;
    ifa.load  = 1'b1;
    tick();
    ifa.load  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (ifa.an !== 4'hF || ifa.seg !== 7'h7F || ifa.dp_n !== 1'b1 || ifa.frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: an=%h seg=%h dp_n=%b frame=%b, expected an=F seg=7F dp_n=1 frame=0",
               ifa.an, ifa.seg, ifa.dp_n, ifa.frame);
    end
    load_a(16'h1234, 4'b0000);
    n_cmp++;
    if (ifa.an !== 4'hE || ifa.seg !== 7'h40) begin
      n_err++;
      $display("FAIL reset_first_edge: an=%h seg=%h, expected an=E seg=40", ifa.an, ifa.seg);
    end
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ifa.an !== 4'hF || ifa.seg !== 7'h7F || ifa.dp_n !== 1'b1 || ifa.frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: an=%h seg=%h dp_n=%b frame=%b, expected an=F seg=7F dp_n=1 frame=0",
               ifa.an, ifa.seg, ifa.dp_n, ifa.frame);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ifa.an !== 4'hE || ifa.seg !== 7'h40) begin
      n_err++;
      $display("FAIL reset_release: an=%h seg=%h, expected an=E seg=40", ifa.an, ifa.seg);
    end
    repeat (16) tick();
    n_cmp++;
    if (ifa.frame !== 1'b1 || ifa.an !== 4'hE || ifa.seg !== 7'h40) begin
      n_err++;
      $display("FAIL reset_discard_pending: an=%h seg=%h frame=%b, expected an=E seg=40 frame=1",
               ifa.an, ifa.seg, ifa.frame);
    end
  endtask

  task automatic test_scan_order();
    do_reset();
    load_a(16'h1234, 4'b0010);
    repeat (15) tick();
    for (int k = 17; k <= 48; k++) begin
      int         d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dpn;
      logic       e_fr;
      tick();
      d     = ((k - 1) / 4) % 4;
      e_an  = an_tab[d];
      e_seg = seg_1234[d];
      e_dpn = (d != 1);
      e_fr  = ((k - 17) % 16 == 0);
      n_cmp++;
      if (ifa.an !== e_an || ifa.seg !== e_seg || ifa.dp_n !== e_dpn || ifa.frame !== e_fr) begin
        n_err++;
        $display("FAIL scan_order k=%0d: an=%h seg=%h dp_n=%b frame=%b, expected an=%h seg=%h dp_n=%b frame=%b",
                 k, ifa.an, ifa.seg, ifa.dp_n, ifa.frame, e_an, e_seg, e_dpn, e_fr);
      end
    end
  endtask

  task automatic test_decode();
    do_reset();
    for (int v = 0; v < 16; v++) begin
      ifb.value = 4'(v);
      ifb.dp    = 1'b0;
      ifb.load  = 1'b1;
      tick();
      ifb.load  = 1'b0;
      if (v > 0) begin
        n_cmp++;
        if (ifb.seg !== seg_tab[v-1] || ifb.an !== 1'b0 || ifb.dp_n !== 1'b1 || ifb.frame !== 1'b1) begin
          n_err++;
          $display("FAIL decode nibble=%h: seg=%h an=%b dp_n=%b frame=%b, expected seg=%h an=0 dp_n=1 frame=1",
                   v - 1, ifb.seg, ifb.an, ifb.dp_n, ifb.frame, seg_tab[v-1]);
        end
      end
      repeat (3) tick();
    end
    tick();
    n_cmp++;
    if (ifb.seg !== seg_tab[15] || ifb.frame !== 1'b1) begin
      n_err++;
      $display("FAIL decode nibble=f: seg=%h frame=%b, expected seg=%h frame=1",
               ifb.seg, ifb.frame, seg_tab[15]);
    end
  endtask

  task automatic test_double_buffer();
    do_reset();
    load_a(16'h8888, 4'b0000);
    repeat (15) tick();
    for (int k = 17; k <= 48; k++) begin
      int         d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fr;
      if (k == 22) begin
        ifa.value = 16'h1111;
        ifa.load  = 1'b1;
      end
      if (k == 26) begin
        ifa.value = 16'h2222;
        ifa.load  = 1'b1;
      end
      tick();
      ifa.load = 1'b0;
      d     = ((k - 1) / 4) % 4;
      e_an  = an_tab[d];
      e_seg = (k <= 32) ? 7'h00 : 7'h24;
      e_fr  = (k == 17) || (k == 33);
      n_cmp++;
      if (ifa.an !== e_an || ifa.seg !== e_seg || ifa.frame !== e_fr) begin
        n_err++;
        $display("FAIL double_buffer k=%0d: an=%h seg=%h frame=%b, expected an=%h seg=%h frame=%b",
                 k, ifa.an, ifa.seg, ifa.frame, e_an, e_seg, e_fr);
      end
    end
  endtask

  task automatic test_blanking();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      load_a(16'h0005, (pass == 0) ? 4'b0000 : 4'b0100);
      repeat (15) tick();
      for (int k = 17; k <= 32; k++) begin
        int         d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpn;
        tick();
        d = ((k - 1) / 4) % 4;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dpn = 1'b1;
        if (d == 0) begin
          e_an  = 4'hE;
          e_seg = 7'h12;
        end else if (pass == 1 && d == 1) begin
          e_an  = 4'hD;
          e_seg = 7'h40;
        end else if (pass == 1 && d == 2) begin
          e_an  = 4'hB;
          e_seg = 7'h40;
          e_dpn = 1'b0;
        end
        n_cmp++;
        if (ifa.an !== e_an || ifa.seg !== e_seg || ifa.dp_n !== e_dpn) begin
          n_err++;
          $display("FAIL blanking pass=%0d k=%0d: an=%h seg=%h dp_n=%b, expected an=%h seg=%h dp_n=%b",
                   pass, k, ifa.an, ifa.seg, ifa.dp_n, e_an, e_seg, e_dpn);
        end
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    load_a(16'h1234, 4'b0000);
    repeat (15) tick();
    for (int k = 17; k <= 56; k++) begin
      int         kk;
      int         d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fr;
      if (k == 27) ifa.enable = 1'b0;
      if (k == 47) ifa.enable = 1'b1;
      tick();
      if (k >= 27 && k <= 46) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_fr  = 1'b0;
      end else begin
        kk    = (k >= 47) ? k - 20 : k;
        d     = ((kk - 1) / 4) % 4;
        e_an  = an_tab[d];
        e_seg = seg_1234[d];
        e_fr  = ((kk - 17) % 16 == 0);
      end
      n_cmp++;
      if (ifa.an !== e_an || ifa.seg !== e_seg || ifa.dp_n !== 1'b1 || ifa.frame !== e_fr) begin
        n_err++;
        $display("FAIL enable k=%0d: an=%h seg=%h dp_n=%b frame=%b, expected an=%h seg=%h dp_n=1 frame=%b",
                 k, ifa.an, ifa.seg, ifa.dp_n, ifa.frame, e_an, e_seg, e_fr);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    ifa.value  = '0;
    ifa.dp     = '0;
    ifa.load   = 1'b0;
    ifa.enable = 1'b1;
    ifb.value  = '0;
    ifb.dp     = '0;
    ifb.load   = 1'b0;
    ifb.enable = 1'b1;

    test_reset();
    test_scan_order();
    test_decode();
    test_double_buffer();
    test_blanking();
    test_enable();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
